// File: rtl/enet_pkg.sv
// Shared Ethernet definitions: framing constants, CRC-32 parameters and the
// TX framer state encoding. Imported by the TX framer and the CRC helper;
// the RX checker reuses the CRC constants and residue.
package enet_pkg;

  localparam logic [7:0]  ENET_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ENET_SFD         = 8'hD5;
  localparam logic [31:0] ENET_CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] ENET_CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] ENET_CRC_RESIDUE = 32'hDEBB20E3;

  // State names the phase of the byte that will be registered onto GMII at
  // the next edge.
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_PRE,
    TX_SFD,
    TX_DATA,
    TX_PAD,
    TX_FCS,
    TX_IFG
  } enet_tx_state_e;

endpackage

// File: rtl/enet_crc32_d8.sv
// Combinational CRC-32 (reflected, poly 0xEDB88320) advance by one byte.
// Ports: crc_in - current CRC register, data - byte (LSB first on the wire),
//        crc_out - CRC register after absorbing data. No latency, no flow control.
module enet_crc32_d8
  import enet_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0] ^ data[i]) begin
        crc_out = (crc_out >> 1) ^ ENET_CRC_POLY;
      end else begin
        crc_out = crc_out >> 1;
      end
    end
  end

endmodule

// File: rtl/enet_gmii_tx_framer.sv
// Ethernet TX framer: byte stream -> GMII frame (preamble, SFD, payload, pad, FCS, IFG).
// Latency: first preamble byte one edge after s_valid seen in IDLE; payload byte one edge after acceptance.
// Backpressure: s_ready only in DATA; s_valid low in DATA aborts the frame (tx_er cycle, underrun pulse).
// Ports: clk/rst (sync, active-high); s_valid/s_data/s_last/s_ready upstream byte stream;
//        tx_busy, frame_done, underrun status; gmii_tx_en/gmii_tx_er/gmii_txd registered to the GMII adapter.
module enet_gmii_tx_framer
  import enet_pkg::*;
#(
  parameter int unsigned IFG_BYTES = 12,
  parameter int unsigned MIN_FRAME = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  output logic       tx_busy,
  output logic       frame_done,
  output logic       underrun,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic [7:0] gmii_txd
);

  localparam logic [7:0] IFG_LAST = 8'(IFG_BYTES - 1);
  localparam logic [9:0] MIN_CNT  = 10'(MIN_FRAME);

  enet_tx_state_e state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;          // preamble / FCS byte / IFG cycle counter
  logic [9:0]     byte_cnt_q, byte_cnt_d;
  logic [31:0]    crc_q, crc_d;
  logic           tx_en_q, tx_en_d;
  logic           tx_er_q, tx_er_d;
  logic [7:0]     txd_q, txd_d;
  logic           frame_done_q, frame_done_d;
  logic           underrun_q, underrun_d;

  logic [7:0]     crc_byte;
  logic [31:0]    crc_next;
  logic [9:0]     byte_cnt_inc;

  // Only DATA and PAD advance the CRC; pad bytes are zero.
  assign crc_byte     = (state_q == TX_DATA) ? s_data : 8'h00;
  assign byte_cnt_inc = (byte_cnt_q == 10'h3FF) ? byte_cnt_q : byte_cnt_q + 10'd1;

  enet_crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data    (crc_byte),
    .crc_out (crc_next)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    byte_cnt_d   = byte_cnt_q;
    crc_d        = crc_q;
    tx_en_d      = 1'b0;
    tx_er_d      = 1'b0;
    txd_d        = 8'h00;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (s_valid) begin
          tx_en_d = 1'b1;
          txd_d   = ENET_PREAMBLE;
          cnt_d   = 8'd1;
          state_d = TX_PRE;
        end
      end
      TX_PRE: begin
        tx_en_d = 1'b1;
        txd_d   = ENET_PREAMBLE;
        if (cnt_q == 8'd6) begin
          cnt_d      = 8'd0;
          crc_d      = ENET_CRC_INIT;
          byte_cnt_d = 10'd0;
          state_d    = TX_SFD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      TX_SFD: begin
        tx_en_d = 1'b1;
        txd_d   = ENET_SFD;
        state_d = TX_DATA;
      end
      TX_DATA: begin
        tx_en_d = 1'b1;
        cnt_d   = 8'd0;
        if (s_valid) begin
          txd_d      = s_data;
          crc_d      = crc_next;
          byte_cnt_d = byte_cnt_inc;
          if (s_last) begin
            state_d = (byte_cnt_inc < MIN_CNT) ? TX_PAD : TX_FCS;
          end
        end else begin
          // Upstream starved mid-frame: poison the frame and skip the FCS.
          tx_er_d    = 1'b1;
          underrun_d = 1'b1;
          state_d    = TX_IFG;
        end
      end
      TX_PAD: begin
        tx_en_d    = 1'b1;
        crc_d      = crc_next;
        byte_cnt_d = byte_cnt_inc;
        cnt_d      = 8'd0;
        if (byte_cnt_inc >= MIN_CNT) begin
          state_d = TX_FCS;
        end
      end
      TX_FCS: begin
        // Shift the register down so each byte is taken from the bottom.
        tx_en_d = 1'b1;
        txd_d   = ~crc_q[7:0];
        crc_d   = {8'h00, crc_q[31:8]};
        if (cnt_q == 8'd3) begin
          frame_done_d = 1'b1;
          cnt_d        = 8'd0;
          state_d      = TX_IFG;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      TX_IFG: begin
        if (cnt_q == IFG_LAST) begin
          cnt_d   = 8'd0;
          state_d = TX_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= TX_IDLE;
      cnt_q        <= 8'd0;
      byte_cnt_q   <= 10'd0;
      crc_q        <= ENET_CRC_INIT;
      tx_en_q      <= 1'b0;
      tx_er_q      <= 1'b0;
      txd_q        <= 8'h00;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      crc_q        <= crc_d;
      tx_en_q      <= tx_en_d;
      tx_er_q      <= tx_er_d;
      txd_q        <= txd_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

  assign s_ready    = (state_q == TX_DATA);
  assign tx_busy    = (state_q != TX_IDLE);
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;
  assign gmii_tx_en = tx_en_q;
  assign gmii_tx_er = tx_er_q;
  assign gmii_txd   = txd_q;

endmodule
